// File: rtl/mem_issue_queue_pkg.sv
// Shared core types for the memory issue path: micro-op layout, functional-unit
// codes, memory access enums and the queue/hold payload record.
package mem_issue_queue_pkg;

    localparam int MEMQ_DEPTH = 4;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MEM = 2'd1,
        FU_BRU = 2'd2,
        FU_MUL = 2'd3
    } fu_code_t;

    typedef enum logic {
        MEM_LD = 1'b0,
        MEM_ST = 1'b1
    } mem_type_t;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_t;

    typedef struct packed {
        logic       valid;
        fu_code_t   fu_code;
        mem_type_t  mem_type;
        mem_size_t  mem_size;
        logic [4:0] rd;
        logic [31:0] imm;
    } micro_op_t;

    // One queued entry and, identically, the issue hold register.
    typedef struct packed {
        micro_op_t   uop;
        logic [31:0] in1;
        logic [31:0] in2;
    } mem_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } issue_state_t;

endpackage

// File: rtl/mem_issue_queue_sync_fifo.sv
// Circular-buffer FIFO with push/pop/flush and an occupancy count; the head
// entry is read combinationally so a consumer can capture it in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;

    always_ff @(posedge clock) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/mem_issue_queue.sv
// In-order memory issue queue: FIFO of memory micro-ops feeding a single-issue
// FSM whose hold register presents one op to the memory pipe until it frees up.
module mem_issue_queue
    import mem_issue_queue_pkg::*;
#(
    parameter int DEPTH = MEMQ_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  micro_op_t              in_uop,
    input  logic [31:0]            in_rs1,
    input  logic [31:0]            in_rs2,
    output logic                   in_ready,
    output micro_op_t              out_uop,
    output logic [31:0]            out_in1,
    output logic [31:0]            out_in2,
    input  logic                   pipe_busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    issue_state_t state_reg, state_next;
    logic         wait_first_reg, wait_first_next;
    mem_entry_t   hold_reg, hold_next;
    mem_entry_t   head_entry;
    mem_entry_t   push_entry;
    logic         push;
    logic         pop;
    logic         has_entry;

    // Readiness uses only the registered count; a same-cycle pop never frees a slot.
    assign in_ready   = (count < DEPTH_C);
    assign push       = in_uop.valid && (in_uop.fu_code == FU_MEM) && in_ready && !flush;
    assign push_entry = '{uop: in_uop, in1: in_rs1, in2: in_rs2};
    assign has_entry  = (count != '0);

    sync_fifo #(
        .WIDTH ($bits(mem_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            wait_first_reg <= 1'b0;
            hold_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            wait_first_reg <= wait_first_next;
            hold_reg       <= hold_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        wait_first_next = 1'b0;
        pop             = 1'b0;
        hold_next       = hold_reg;
        case (state_reg)
            IDLE: begin
                if (has_entry && !pipe_busy && !flush) begin
                    pop        = 1'b1;
                    hold_next  = head_entry;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // The op is already on the pipe, so a flush here still waits it out.
                state_next      = WAIT;
                wait_first_next = 1'b1;
            end
            WAIT: begin
                // Busy only becomes meaningful one cycle after the valid pulse.
                if (!wait_first_reg && !pipe_busy) begin
                    if (has_entry && !flush) begin
                        pop        = 1'b1;
                        hold_next  = head_entry;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_uop       = hold_reg.uop;
        out_uop.valid = (state_reg == ISSUE);
    end

    assign out_in1 = hold_reg.in1;
    assign out_in2 = hold_reg.in2;

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench for mem_issue_queue: a queue-based issue model checked every
// cycle, plus literal expectations for each scenario.
module tb_mem_issue_queue;
    import mem_issue_queue_pkg::*;

    localparam int DEPTH = MEMQ_DEPTH;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   flush;
    logic                   pipe_busy;
    micro_op_t              in_uop;
    micro_op_t              out_uop;
    logic [31:0]            in_rs1, in_rs2, out_in1, out_in2;
    logic                   in_ready;
    logic [$clog2(DEPTH):0] count;

    int errors = 0;
    int checks = 0;

    mem_issue_queue #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_uop    (in_uop),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_ready  (in_ready),
        .out_uop   (out_uop),
        .out_in1   (out_in1),
        .out_in2   (out_in2),
        .pipe_busy (pipe_busy),
        .count     (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: an issued op is outstanding from its valid cycle until the first
    // cycle at least two later that sees pipe_busy low; the next head may issue
    // from that cycle (or any idle cycle) when the pipe is free and no flush.
    mem_entry_t mq[$];
    mem_entry_t m_hold;
    logic       m_valid = 1'b0;
    logic       m_out = 1'b0;
    logic       m_live = 1'b0;
    int         m_v = 0;
    int         m_cyc = 0;

    always @(posedge clock) begin
        automatic int   sz  = mq.size();
        automatic logic acc = 1'b0;
        automatic logic iss = 1'b0;
        if (reset) begin
            mq.delete();
            m_hold  = '0;
            m_valid = 1'b0;
            m_out   = 1'b0;
            m_live  = 1'b1;
        end else begin
            acc = in_uop.valid && (in_uop.fu_code == FU_MEM) && (sz < DEPTH) && !flush;
            if ((!m_out || m_cyc >= m_v + 2) && !pipe_busy) begin
                m_out = 1'b0;
                if (sz > 0 && !flush) begin
                    m_hold = mq.pop_front();
                    iss    = 1'b1;
                    m_out  = 1'b1;
                    m_v    = m_cyc + 1;
                end
            end
            if (flush) mq.delete();
            else if (acc) mq.push_back({in_uop, in_rs1, in_rs2});
            m_valid = iss;
        end
        m_cyc++;
    end

    always @(negedge clock) begin : compare
        micro_op_t e;
        if (m_live) begin
            e       = m_hold.uop;
            e.valid = m_valid;
            chk("out_uop", 64'(out_uop), 64'(e));
            chk("out_in1", 64'(out_in1), 64'(m_hold.in1));
            chk("out_in2", 64'(out_in2), 64'(m_hold.in2));
            chk("count", 64'(count), 64'(mq.size()));
            chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
            if (out_uop.valid)
                $display("issue t=%0t type=%0d imm=%0h in1=%0h in2=%0h count=%0d",
                         $time, out_uop.mem_type, out_uop.imm, out_in1, out_in2, count);
        end
    end

    function automatic micro_op_t mk(input fu_code_t f, input mem_type_t t,
                                     input logic [31:0] imm, input logic [4:0] rd);
        micro_op_t u;
        u          = '0;
        u.valid    = 1'b1;
        u.fu_code  = f;
        u.mem_type = t;
        u.mem_size = MEM_W;
        u.imm      = imm;
        u.rd       = rd;
        return u;
    endfunction

    task automatic tick(input micro_op_t u, input logic [31:0] a, input logic [31:0] b,
                        input logic busy, input logic fl, input logic rst);
        in_uop    = u;
        in_rs1    = a;
        in_rs2    = b;
        pipe_busy = busy;
        flush     = fl;
        reset     = rst;
        @(negedge clock);
    endtask

    initial begin
        micro_op_t nop;
        int        k;
        int        n;
        int        c0, c1;
        logic [31:0] v0, v1;
        logic      prev_v;
        logic      any_v;
        logic [6:0] busy_seq;

        nop = '0;

        // Reset
        tick(nop, 0, 0, 0, 0, 1);
        tick(nop, 0, 0, 0, 0, 1);
        tick(nop, 0, 0, 0, 0, 0);
        chk("rst_out_uop", 64'(out_uop), 64'd0);
        chk("rst_in1", 64'(out_in1), 64'd0);
        chk("rst_in2", 64'(out_in2), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);

        // Single load, busy arrives 3 cycles after valid
        tick(mk(FU_MEM, MEM_LD, 32'd4, 5'd1), 32'h1000, 32'h0, 0, 0, 0);
        tick(nop, 0, 0, 0, 0, 0);
        chk("ld_valid", 64'(out_uop.valid), 64'd1);
        chk("ld_in1", 64'(out_in1), 64'h1000);
        chk("ld_imm", 64'(out_uop.imm), 64'd4);
        busy_seq = 7'b0011000;
        for (int i = 0; i < 6; i++) tick(nop, 0, 0, busy_seq[6-i], 0, 0);
        chk("ld_valid_after", 64'(out_uop.valid), 64'd0);
        chk("ld_in1_held", 64'(out_in1), 64'h1000);

        // Fill with pipe busy, then a push on full while popping
        for (int i = 0; i < 5; i++)
            tick(mk(FU_MEM, MEM_ST, 32'(i), 5'(i)), 32'h10 + 32'(i), 32'h0, 1, 0, 0);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_ready", 64'(in_ready), 64'd0);
        tick(mk(FU_MEM, MEM_ST, 32'd5, 5'd5), 32'h15, 32'h0, 0, 0, 0);
        chk("full_pop_count", 64'(count), 64'd3);
        k = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_uop.valid) begin
                chk("drain_order", 64'(out_in1), 64'h10 + 64'(k));
                k++;
            end
            tick(nop, 0, 0, 0, 0, 0);
        end
        chk("drain_total", 64'(k), 64'd4);

        // Back-to-back stores, pipe busy for one cycle after each valid
        prev_v = 1'b0;
        n = 0; c0 = 0; c1 = 0; v0 = 0; v1 = 0;
        for (int i = 0; i < 12; i++) begin
            tick((i == 0) ? mk(FU_MEM, MEM_ST, 32'h8, 5'd2) :
                 (i == 1) ? mk(FU_MEM, MEM_ST, 32'hC, 5'd3) : nop,
                 32'h2000 + 32'(i),
                 (i == 0) ? 32'hAAAA : (i == 1) ? 32'h5555 : 32'h0,
                 prev_v, 0, 0);
            prev_v = out_uop.valid;
            if (out_uop.valid) begin
                if (n == 0) begin c0 = i; v0 = out_in2; end
                else        begin c1 = i; v1 = out_in2; end
                n++;
            end
        end
        chk("st_pulses", 64'(n), 64'd2);
        chk("st_gap", 64'(c1 - c0), 64'd3);
        chk("st_rs2_first", 64'(v0), 64'hAAAA);
        chk("st_rs2_second", 64'(v1), 64'h5555);

        // Flush in WAIT with 3 queued, plus a same-cycle enqueue
        tick(mk(FU_MEM, MEM_LD, 32'h0, 5'd4), 32'h3000, 0, 0, 0, 0);
        tick(mk(FU_MEM, MEM_LD, 32'h1, 5'd5), 32'h3001, 0, 0, 0, 0);
        tick(mk(FU_MEM, MEM_LD, 32'h2, 5'd6), 32'h3002, 0, 1, 0, 0);
        tick(mk(FU_MEM, MEM_LD, 32'h3, 5'd7), 32'h3003, 0, 1, 0, 0);
        chk("pre_flush_count", 64'(count), 64'd3);
        tick(mk(FU_MEM, MEM_LD, 32'h4, 5'd8), 32'h3004, 0, 1, 1, 0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_in1_held", 64'(out_in1), 64'h3000);
        any_v = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(nop, 0, 0, (i == 0), 0, 0);
            any_v |= out_uop.valid;
        end
        chk("flush_no_valid", 64'(any_v), 64'd0);
        chk("flush_in1_after", 64'(out_in1), 64'h3000);

        // Non-MEM uop ignored; simultaneous push/pop at count 2
        tick(mk(FU_MEM, MEM_LD, 32'h10, 5'd9), 32'h4000, 0, 1, 0, 0);
        tick(mk(FU_MEM, MEM_ST, 32'h11, 5'd10), 32'h4001, 32'h77, 1, 0, 0);
        tick(mk(FU_ALU, MEM_LD, 32'h12, 5'd11), 32'h4002, 0, 1, 0, 0);
        chk("alu_ignored_count", 64'(count), 64'd2);
        tick(mk(FU_MEM, MEM_LD, 32'h13, 5'd12), 32'h4003, 0, 0, 0, 0);
        chk("pushpop_count", 64'(count), 64'd2);
        chk("pushpop_head", 64'(out_in1), 64'h4000);
        for (int i = 0; i < 10; i++) tick(nop, 0, 0, 0, 0, 0);

        // Reset during ISSUE overrides a same-cycle enqueue
        tick(mk(FU_MEM, MEM_LD, 32'h20, 5'd13), 32'h5000, 0, 0, 0, 0);
        tick(nop, 0, 0, 0, 0, 0);
        chk("pre_rst_valid", 64'(out_uop.valid), 64'd1);
        tick(mk(FU_MEM, MEM_LD, 32'h21, 5'd14), 32'h5001, 0, 0, 0, 1);
        chk("mid_rst_out_uop", 64'(out_uop), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        tick(nop, 0, 0, 0, 0, 0);
        tick(nop, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_issue_queue.md
MEM_ISSUE_QUEUE -- requirements
Module: mem_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4 (power of 2, >=2): number of queued memory micro-ops.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  discard all queued, not-yet-issued entries.
REQ-005 in_uop  input  micro_op_t  micro-op from register read; enqueue candidate.
REQ-006 in_rs1  input  32  operand 1 (base address).
REQ-007 in_rs2  input  32  operand 2 (store data).
REQ-008 in_ready  output  1  queue can accept an entry this cycle.
REQ-009 out_uop  output  micro_op_t  micro-op to the memory pipe.
REQ-010 out_in1  output  32  operand 1 to the memory pipe.
REQ-011 out_in2  output  32  operand 2 to the memory pipe.
REQ-012 pipe_busy  input  1  memory pipe busy (load/store in flight).
REQ-013 count  output  $clog2(DEPTH)+1  number of valid queued entries, excluding the hold register.

Function
REQ-014 Enqueue SHALL occur when in_uop.valid & in_uop.fu_code==FU_MEM & in_ready & !flush; other valid uops SHALL be ignored.
REQ-015 in_ready SHALL be (count < DEPTH), computed from registered state, with no same-cycle pop bypass.
REQ-016 Queue SHALL be strict FIFO: loads and stores issue in enqueue order, with circular read/write pointers wrapping at DEPTH.
REQ-017 Issue FSM SHALL have states IDLE, ISSUE and WAIT, plus a hold register {uop, in1, in2} driving out_*.
REQ-018 IDLE: if count>0 & !pipe_busy & !flush, load the head into hold, pop it and go to ISSUE; else stay.
REQ-019 ISSUE: out_uop.valid SHALL be 1 for exactly this one cycle, then go to WAIT.
REQ-020 WAIT: out_uop.valid SHALL be 0, with out_uop (all other fields), out_in1 and out_in2 held stable.
REQ-021 WAIT exit: leave when pipe_busy==0. Go to ISSUE if count>0 & !flush (loading the next head); otherwise go to IDLE.
REQ-022 The first WAIT cycle SHALL NOT sample pipe_busy, because the pipe asserts busy one cycle after valid; WAIT lasts at least 2 cycles.
REQ-023 Payload hold SHALL be maintained while in WAIT, because the memory pipe reads uop.imm, uop.mem_size and in1/in2 combinationally while busy.
REQ-024 Latency: with an empty queue and IDLE state, an entry enqueued at edge N SHALL appear with out_uop.valid=1 in the cycle after edge N+1.
REQ-025 Simultaneous enqueue and pop SHALL leave count unchanged; when full, a pop in the same cycle SHALL NOT enable enqueue.
REQ-026 flush SHALL zero count and pointers next cycle and drop a same-cycle enqueue.
REQ-027 On flush, ISSUE SHALL go to WAIT, because the op is already presented to the pipe.
REQ-028 On flush, WAIT SHALL keep its hold payload until pipe_busy drops, then go to IDLE.
REQ-029 On flush, IDLE SHALL remain IDLE.
REQ-030 out_uop.valid SHALL never be 1 in two consecutive cycles.

Reset
REQ-031 On reset the FSM SHALL go to IDLE, count and pointers to 0, and the hold register to 0.
REQ-032 Outputs after reset: out_uop all zero, out_in1=out_in2=0, in_ready=1.
REQ-033 Reset asserted mid-operation SHALL override flush, enqueue and the FSM, taking effect at the next edge.

Structure
REQ-034 micro_op_t, the FU_MEM code and the mem_type/mem_size enums SHALL come from the shared core package; DEPTH default SHALL be a package constant MEMQ_DEPTH.
REQ-035 Storage SHALL be one sub-module, sync_fifo (parameterised width/depth, with push, pop, flush, count); the FSM and hold register SHALL live in mem_issue_queue.

Verification
REQ-036 Single load: enqueue FU_MEM LD, rs1=0x1000, imm=4; pipe_busy asserted 3 cycles after valid -> valid pulse 1 cycle, out_in1=0x1000 held until busy drops.
REQ-037 Fill: 5 back-to-back enqueues, DEPTH=4, pipe_busy=1 -> count=4, in_ready=0, 5th dropped, order preserved on drain.
REQ-038 Back-to-back store pair, each with pipe_busy high 1 cycle -> valid pulses 3 cycles apart; rs2 values 0xAAAA then 0x5555 in order.
REQ-039 Flush in WAIT with 3 queued -> count=0 next cycle; payload held until pipe_busy=0; no further valid.
REQ-040 Non-MEM valid uop (FU_ALU) plus simultaneous enqueue/pop at count=2 -> ALU ignored; count stays 2.
REQ-041 Reset asserted during ISSUE -> next cycle out_uop=0, count=0, in_ready=1.
